// File: rtl/input_scheduler.sv
// input_scheduler: turns key levels, frame strobe, gravity and lock timing into
// one game command at a time, offered to the board FSM over a valid/ack handshake.
module input_scheduler #(
  parameter int CNT_W       = 6,
  parameter int DAS_FRAMES  = 10,
  parameter int ARR_FRAMES  = 2,
  parameter int LOCK_FRAMES = 30,
  parameter int SOFT_PERIOD = 2
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_rotl,
  input  logic             key_rotr,
  input  logic             key_hold,
  input  logic             ground,
  input  logic [CNT_W-1:0] gravity_period,
  input  logic             cmd_ack,
  output logic             cmd_valid,
  output logic [2:0]       cmd
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DAS_N  = CNT_W'(DAS_FRAMES);
  localparam logic [CNT_W-1:0] ARR_N  = CNT_W'(ARR_FRAMES);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] SOFT_N = CNT_W'(SOFT_PERIOD);
  state_t state_q, state_d;
  // pending flags are indexed by command code
  logic [7:1] pend_q, pend_d, set, clr;
  logic [4:0] keys, edges, keys_q, keys_d;
  logic [CNT_W-1:0] das_q, das_d, arr_q, arr_d, grav_q, grav_d, lock_q, lock_d, period;
  logic valid_q, valid_d, ack, lock_ack, rep, fall, lock_ev;
  logic [2:0] cmd_q, cmd_d, sel;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + ONE;
  endfunction

  assign keys = {key_hold, key_rotr, key_rotl, key_right, key_left};
  assign edges = keys & ~keys_q;
  assign period = key_down ? SOFT_N : (gravity_period == '0 ? ONE : gravity_period);
  assign ack = cmd_ack & valid_q;
  assign lock_ack = ack & (cmd_q == 3'd7);
  assign sel = pend_q[7] ? 3'd7 : pend_q[5] ? 3'd5 : pend_q[3] ? 3'd3 : pend_q[4] ? 3'd4 :
               pend_q[1] ? 3'd1 : pend_q[2] ? 3'd2 : 3'd6;
  assign set = {lock_ev, fall, edges[4:2], edges[1] | (rep & key_right), edges[0] | (rep & key_left)};
  assign cmd_valid = valid_q;
  assign cmd = cmd_q;

  always_comb begin
    das_d = das_q;
    arr_d = arr_q;
    grav_d = grav_q;
    lock_d = lock_q;
    rep = 1'b0;
    fall = 1'b0;
    lock_ev = 1'b0;
    if (!(key_left ^ key_right)) begin
      das_d = '0;
      arr_d = '0;
    end else if (frame_tick && das_q != DAS_N) begin
      das_d = inc(das_q);
      rep = das_d == DAS_N;
    end else if (frame_tick) begin
      arr_d = inc(arr_q);
      rep = arr_d >= ARR_N;
      arr_d = rep ? '0 : arr_d;
    end
    if (ground) grav_d = '0;
    else if (frame_tick) begin
      grav_d = inc(grav_q);
      fall = grav_d >= period;
      grav_d = fall ? '0 : grav_d;
    end
    if (!ground) lock_d = '0;
    else if (frame_tick) begin
      lock_d = inc(lock_q);
      lock_ev = lock_d == LOCK_N;
    end
    // a successful shift or rotate on the ground buys a fresh lock delay
    if (ack && ground && cmd_q <= 3'd4) lock_d = '0;
    if (lock_ack || !enable) begin
      das_d = '0;
      arr_d = '0;
      grav_d = '0;
      lock_d = '0;
    end
  end

  always_comb begin
    for (int i = 1; i <= 7; i++) clr[i] = lock_ack | (ack & (cmd_q == 3'(i)));
    pend_d = enable ? (pend_q & ~clr) | set : '0;
    keys_d = keys;
    state_d = state_q;
    valid_d = valid_q;
    cmd_d = cmd_q;
    if (state_q == S_ISSUE) begin
      if (ack) begin
        state_d = S_GAP;
        valid_d = 1'b0;
        cmd_d = '0;
      end
    end else begin
      state_d = |pend_q ? S_ISSUE : S_IDLE;
      valid_d = |pend_q;
      cmd_d = |pend_q ? sel : 3'd0;
    end
    if (!enable) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      cmd_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pend_q <= '0;
      keys_q <= '0;
      das_q <= '0;
      arr_q <= '0;
      grav_q <= '0;
      lock_q <= '0;
      valid_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      keys_q <= keys_d;
      das_q <= das_d;
      arr_q <= arr_d;
      grav_q <= grav_d;
      lock_q <= lock_d;
      valid_q <= valid_d;
      cmd_q <= cmd_d;
    end
  end
endmodule

// File: tb/tb_input_scheduler.sv
// tb_input_scheduler: directed table and frame sequences plus randomized traffic against a command-level model.
module tb_input_scheduler;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, en = 1'b1;
  logic kl = 1'b0, kr = 1'b0, kd = 1'b0, krl = 1'b0, krr = 1'b0, kh = 1'b0, gnd = 1'b0, ack = 1'b0;
  logic [5:0] gp = 6'd0;
  logic cmd_valid;
  logic [2:0] cmd;
  int vectors = 0, miscompares = 0;
  int got[$], expq[$];

  bit [7:1] m_pend;
  bit [4:0] m_prev;
  int m_cmd, m_held, m_grav, m_lock;
  int prio[7] = '{7, 5, 3, 4, 1, 2, 6};

  typedef struct {
    logic rotl, hold, left, ack;
    logic v;
    logic [2:0] c;
  } vec_t;
  vec_t tbl[16];

  input_scheduler dut (
    .Clk(clk), .RESET(rst), .frame_tick(tick), .enable(en),
    .key_left(kl), .key_right(kr), .key_down(kd), .key_rotl(krl), .key_rotr(krr), .key_hold(kh),
    .ground(gnd), .gravity_period(gp), .cmd_ack(ack), .cmd_valid(cmd_valid), .cmd(cmd)
  );

  always #5 clk = ~clk;

  // Model: pending set per command, one offered command, timers as plain tick counts.
  task automatic mstep();
    bit [7:1] set, old;
    bit [4:0] keys;
    bit a;
    int p;
    keys = {kh, krr, krl, kr, kl};
    if (rst || !en) begin
      m_pend = '0; m_cmd = 0; m_held = 0; m_grav = 0; m_lock = 0;
      m_prev = rst ? 5'd0 : keys;
      return;
    end
    set = '0;
    for (int i = 0; i < 5; i++) set[i+1] = keys[i] && !m_prev[i];
    m_prev = keys;
    if (kl ^ kr) begin
      if (tick) begin
        m_held++;
        if (m_held >= 10 && (m_held - 10) % 2 == 0) set[kl ? 1 : 2] = 1'b1;
      end
    end else m_held = 0;
    p = kd ? 2 : (gp == 0 ? 1 : int'(gp));
    if (gnd) m_grav = 0;
    else if (tick) begin
      m_grav++;
      if (m_grav >= p) begin set[6] = 1'b1; m_grav = 0; end
    end
    if (!gnd) m_lock = 0;
    else if (tick) begin
      m_lock++;
      if (m_lock == 30) set[7] = 1'b1;
    end
    a = ack && m_cmd != 0;
    old = m_pend;
    if (a && gnd && m_cmd <= 4) m_lock = 0;
    if (a && m_cmd == 7) begin
      m_pend = '0; m_held = 0; m_grav = 0; m_lock = 0;
    end else if (a) m_pend[m_cmd] = 1'b0;
    m_pend |= set;
    if (m_cmd != 0) begin
      if (a) m_cmd = 0;
    end else begin
      for (int i = 0; i < 7; i++) if (old[prio[i]]) begin m_cmd = prio[i]; break; end
    end
  endtask

  task automatic cyc();
    mstep();
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [2:0] ec, logic ev);
    vectors++;
    if (cmd_valid !== ev || cmd !== ec) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b cmd=%0d, expected valid=%0b cmd=%0d", name, cmd_valid, cmd, ev, ec);
    end
  endtask

  task automatic chk_int(string name, int g, int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, g, e);
    end
  endtask

  // Frames are 4 cycles, tick on the first cycle of every frame after frame 0.
  task automatic frames(int n, logic [2:0] watch, int tap);
    got.delete();
    for (int f = 0; f < n; f++)
      for (int c = 0; c < 4; c++) begin
        tick = (f > 0 && c == 0);
        if (f == tap) kl = (c == 1);
        cyc();
        if (cmd_valid && cmd == watch) got.push_back(f);
      end
    tick = 1'b0;
  endtask

  task automatic cmp_list(string name);
    chk_int({name, " count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk_int($sformatf("%s[%0d]", name, i), got[i], expq[i]);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 3'd0};
    tbl[1]  = '{0, 0, 0, 0, 1, 3'd3};
    tbl[2]  = '{0, 0, 0, 0, 1, 3'd3};
    tbl[3]  = '{0, 0, 0, 0, 1, 3'd3};
    tbl[4]  = '{0, 0, 0, 1, 0, 3'd0};
    tbl[5]  = '{0, 0, 0, 0, 0, 3'd0};
    tbl[6]  = '{0, 0, 0, 1, 0, 3'd0};
    tbl[7]  = '{1, 1, 1, 0, 0, 3'd0};
    tbl[8]  = '{1, 1, 1, 0, 1, 3'd5};
    tbl[9]  = '{1, 1, 1, 1, 0, 3'd0};
    tbl[10] = '{1, 1, 1, 0, 1, 3'd3};
    tbl[11] = '{1, 1, 1, 1, 0, 3'd0};
    tbl[12] = '{1, 1, 1, 0, 1, 3'd1};
    tbl[13] = '{1, 1, 1, 1, 0, 3'd0};
    tbl[14] = '{1, 1, 1, 0, 0, 3'd0};
    tbl[15] = '{0, 0, 0, 0, 0, 3'd0};
    cyc();
    cyc();
    chk("reset", 3'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      krl = tbl[i].rotl; kh = tbl[i].hold; kl = tbl[i].left; ack = tbl[i].ack;
      cyc();
      chk($sformatf("tbl%0d", i), tbl[i].c, tbl[i].v);
    end
    gnd = 1'b1; kl = 1'b1; ack = 1'b1;
    frames(20, 3'd1, -1);
    expq = '{0, 10, 12, 14, 16, 18};
    cmp_list("das_arr");
    kl = 1'b0; gnd = 1'b0; gp = 6'd0;
    cyc();
    frames(7, 3'd6, -1);
    expq = '{1, 2, 3, 4, 5, 6};
    cmp_list("grav_p0");
    kd = 1'b1; gp = 6'd20;
    frames(9, 3'd6, -1);
    expq = '{2, 4, 6, 8};
    cmp_list("grav_soft");
    kd = 1'b0; gp = 6'd3;
    frames(7, 3'd6, -1);
    expq = '{3, 6};
    cmp_list("grav_p3");
    gnd = 1'b1;
    frames(32, 3'd7, -1);
    expq = '{30};
    cmp_list("lock");
    gnd = 1'b0;
    cyc();
    gnd = 1'b1;
    frames(52, 3'd7, 20);
    expq = '{50};
    cmp_list("lock_reset");
    gnd = 1'b0; ack = 1'b0; gp = 6'd63;
    krr = 1'b1; kh = 1'b1;
    cyc(); chk("en_edge", 3'd0, 1'b0);
    krr = 1'b0; kh = 1'b0;
    cyc(); chk("en_issue", 3'd5, 1'b1);
    cyc(); chk("en_hold", 3'd5, 1'b1);
    en = 1'b0;
    cyc(); chk("en_drop", 3'd0, 1'b0);
    en = 1'b1;
    cyc(); chk("en_flags0", 3'd0, 1'b0);
    cyc(); chk("en_flags1", 3'd0, 1'b0);
    en = 1'b0; kl = 1'b1;
    cyc();
    en = 1'b1;
    cyc(); chk("en_noedge0", 3'd0, 1'b0);
    cyc(); chk("en_noedge1", 3'd0, 1'b0);
    ack = 1'b1;
    frames(12, 3'd1, -1);
    expq = '{10};
    cmp_list("en_das");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("reset2", 3'd0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      tick = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 59) == 0) kl = ~kl;
      if ($urandom_range(0, 59) == 0) kr = ~kr;
      if ($urandom_range(0, 59) == 0) krl = ~krl;
      if ($urandom_range(0, 59) == 0) krr = ~krr;
      if ($urandom_range(0, 59) == 0) kh = ~kh;
      if ($urandom_range(0, 99) == 0) kd = ~kd;
      if ($urandom_range(0, 199) == 0) gnd = ~gnd;
      if ($urandom_range(0, 99) == 0) gp = 6'($urandom_range(0, 5));
      en = $urandom_range(0, 299) != 0;
      rst = $urandom_range(0, 1999) == 0;
      ack = (m_cmd != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cyc();
      chk("rand", 3'(m_cmd), m_cmd != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
